// File: rtl/mips_writeback_stage_if.sv
// Memory-stage handshake, load-data return and register-array write port of the writeback stage.
// master = upstream/environment side, slave = the writeback stage itself.
interface mips_writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [31:0] in_alu_result;
  logic [1:0]  in_load_size;
  logic        in_load_signed;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        w_r;
  logic        err_misaligned;
  logic        err_timeout;

  modport master (
    output in_valid, in_rd, in_reg_write, in_mem_to_reg, in_alu_result,
           in_load_size, in_load_signed, mem_rdata, mem_rvalid,
    input  in_ready, w_addr, w_data, w_r, err_misaligned, err_timeout
  );

  modport slave (
    input  in_valid, in_rd, in_reg_write, in_mem_to_reg, in_alu_result,
           in_load_size, in_load_signed, mem_rdata, mem_rvalid,
    output in_ready, w_addr, w_data, w_r, err_misaligned, err_timeout
  );
endinterface

// File: rtl/mips_writeback_stage.sv
// MIPS writeback: retires ALU results in 1 cycle, loads 1 cycle after mem_rvalid; one registered write pulse each.
// in_ready is high only in IDLE, so a pending load stalls the memory stage until data or timeout.
module mips_writeback_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  mips_writeback_stage_if.slave wb
);

  typedef enum logic {IDLE, WAIT_LOAD} state_e;

  localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [4:0]  rd_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic        wq_q;
  logic [4:0]  w_addr_q;
  logic [31:0] w_data_q;
  logic        w_r_q;
  logic        err_mis_q;
  logic        err_to_q;

  logic        misaligned_d;
  logic [31:0] shifted_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] ext_d;

  always_comb begin
    misaligned_d = 1'b0;
    case (wb.in_load_size)
      2'b00:   misaligned_d = 1'b0;
      2'b01:   misaligned_d = wb.in_alu_result[0];
      default: misaligned_d = (wb.in_alu_result[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    shifted_d = wb.mem_rdata >> {lane_q, 3'b000};
    byte_d    = shifted_d[7:0];
    half_d    = lane_q[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];
    ext_d     = wb.mem_rdata;
    case (size_q)
      2'b00:   ext_d = signed_q ? {{24{byte_d[7]}}, byte_d} : {24'b0, byte_d};
      2'b01:   ext_d = signed_q ? {{16{half_d[15]}}, half_d} : {16'b0, half_d};
      default: ext_d = wb.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      rd_q      <= 5'd0;
      size_q    <= 2'd0;
      signed_q  <= 1'b0;
      lane_q    <= 2'd0;
      wq_q      <= 1'b0;
      w_addr_q  <= 5'd0;
      w_data_q  <= 32'd0;
      w_r_q     <= 1'b0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      w_r_q     <= 1'b0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wb.in_valid) begin
            if (!wb.in_mem_to_reg) begin
              if (wb.in_reg_write && (wb.in_rd != 5'd0)) begin
                w_r_q    <= 1'b1;
                w_addr_q <= wb.in_rd;
                w_data_q <= wb.in_alu_result;
              end
            end else if (misaligned_d) begin
              err_mis_q <= 1'b1;
            end else begin
              // Loads with no architectural destination still consume their data beat.
              state_q  <= WAIT_LOAD;
              cnt_q    <= 8'd0;
              rd_q     <= wb.in_rd;
              size_q   <= wb.in_load_size;
              signed_q <= wb.in_load_signed;
              lane_q   <= wb.in_alu_result[1:0];
              wq_q     <= wb.in_reg_write && (wb.in_rd != 5'd0);
            end
          end
        end
        WAIT_LOAD: begin
          // Data beats the timeout when both land on the same edge.
          if (wb.mem_rvalid) begin
            if (wq_q) begin
              w_r_q    <= 1'b1;
              w_addr_q <= rd_q;
              w_data_q <= ext_d;
            end
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            err_to_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.in_ready       = (state_q == IDLE);
  assign wb.w_addr         = w_addr_q;
  assign wb.w_data         = w_data_q;
  assign wb.w_r            = w_r_q;
  assign wb.err_misaligned = err_mis_q;
  assign wb.err_timeout    = err_to_q;

endmodule

// File: tb/tb_mips_writeback_stage.sv
// Directed bench for mips_writeback_stage with LOAD_TIMEOUT = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mips_writeback_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  mips_writeback_stage_if wb_if ();

  mips_writeback_stage #(.LOAD_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_if.in_valid       = 1'b0;
    wb_if.in_rd          = 5'd0;
    wb_if.in_reg_write   = 1'b0;
    wb_if.in_mem_to_reg  = 1'b0;
    wb_if.in_alu_result  = 32'd0;
    wb_if.in_load_size   = 2'd0;
    wb_if.in_load_signed = 1'b0;
    wb_if.mem_rdata      = 32'd0;
    wb_if.mem_rvalid     = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr);
    wb_if.in_valid       = 1'b1;
    wb_if.in_rd          = rd;
    wb_if.in_reg_write   = 1'b1;
    wb_if.in_mem_to_reg  = 1'b1;
    wb_if.in_alu_result  = addr;
    wb_if.in_load_size   = size;
    wb_if.in_load_signed = sgn;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    n_cmp++; if (wb_if.w_r !== 1'b0) begin n_bad++; $display("FAIL reset_w_r: got %b want 0", wb_if.w_r); end
    n_cmp++; if (wb_if.w_addr !== 5'd0) begin n_bad++; $display("FAIL reset_w_addr: got %0d want 0", wb_if.w_addr); end
    n_cmp++; if (wb_if.w_data !== 32'd0) begin n_bad++; $display("FAIL reset_w_data: got %h want 0", wb_if.w_data); end
    n_cmp++; if ({wb_if.err_misaligned, wb_if.err_timeout} !== 2'b00) begin n_bad++; $display("FAIL reset_errs: got %b want 00", {wb_if.err_misaligned, wb_if.err_timeout}); end
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (wb_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", wb_if.in_ready); end
    n_cmp++; if (wb_if.w_r !== 1'b0) begin n_bad++; $display("FAIL post_reset_w_r: got %b want 0", wb_if.w_r); end
  endtask

  task automatic test_back_to_back();
    wb_if.in_valid = 1'b1; wb_if.in_reg_write = 1'b1; wb_if.in_mem_to_reg = 1'b0;
    wb_if.in_rd = 5'd5; wb_if.in_alu_result = 32'h1234_5678;
    step();
    n_cmp++; if ({wb_if.w_r, wb_if.w_addr, wb_if.w_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin n_bad++; $display("FAIL b2b_first: got r=%b a=%0d d=%h want r=1 a=5 d=12345678", wb_if.w_r, wb_if.w_addr, wb_if.w_data); end
    n_cmp++; if (wb_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", wb_if.in_ready); end
    wb_if.in_rd = 5'd6; wb_if.in_alu_result = 32'hDEAD_BEEF;
    step();
    n_cmp++; if ({wb_if.w_r, wb_if.w_addr, wb_if.w_data} !== {1'b1, 5'd6, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL b2b_second: got r=%b a=%0d d=%h want r=1 a=6 d=deadbeef", wb_if.w_r, wb_if.w_addr, wb_if.w_data); end
    idle_inputs();
    step();
    n_cmp++; if ({wb_if.w_r, wb_if.w_addr, wb_if.w_data} !== {1'b0, 5'd6, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL b2b_hold: got r=%b a=%0d d=%h want r=0 a=6 d=deadbeef", wb_if.w_r, wb_if.w_addr, wb_if.w_data); end
  endtask

  task automatic test_no_write();
    wb_if.in_valid = 1'b1; wb_if.in_reg_write = 1'b1; wb_if.in_rd = 5'd0; wb_if.in_alu_result = 32'hAAAA_5555;
    step();
    n_cmp++; if (wb_if.w_r !== 1'b0) begin n_bad++; $display("FAIL write_r0: got w_r=%b want 0", wb_if.w_r); end
    wb_if.in_reg_write = 1'b0; wb_if.in_rd = 5'd7;
    step();
    n_cmp++; if (wb_if.w_r !== 1'b0) begin n_bad++; $display("FAIL no_reg_write: got w_r=%b want 0", wb_if.w_r); end
    idle_inputs();
    wb_if.mem_rvalid = 1'b1; wb_if.mem_rdata = 32'h5555_AAAA;
    step();
    n_cmp++; if ({wb_if.w_r, wb_if.err_misaligned, wb_if.err_timeout, wb_if.w_data} !== {3'b000, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL idle_rvalid: got r=%b em=%b et=%b d=%h want 0 0 0 deadbeef", wb_if.w_r, wb_if.err_misaligned, wb_if.err_timeout, wb_if.w_data); end
    idle_inputs();
  endtask

  task automatic test_signed_byte();
    drive_load(5'd9, 2'b00, 1'b1, 32'h0000_1003);
    step();
    idle_inputs();
    n_cmp++; if (wb_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL sbyte_stall: got in_ready=%b want 0", wb_if.in_ready); end
    step();
    step();
    n_cmp++; if (wb_if.w_r !== 1'b0) begin n_bad++; $display("FAIL sbyte_early: got w_r=%b want 0", wb_if.w_r); end
    wb_if.mem_rvalid = 1'b1; wb_if.mem_rdata = 32'h80FF_0011;
    step();
    idle_inputs();
    n_cmp++; if ({wb_if.w_r, wb_if.w_addr, wb_if.w_data} !== {1'b1, 5'd9, 32'hFFFF_FF80}) begin n_bad++; $display("FAIL sbyte_write: got r=%b a=%0d d=%h want r=1 a=9 d=ffffff80", wb_if.w_r, wb_if.w_addr, wb_if.w_data); end
    n_cmp++; if (wb_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL sbyte_ready: got %b want 1", wb_if.in_ready); end
    step();
    n_cmp++; if (wb_if.w_r !== 1'b0) begin n_bad++; $display("FAIL sbyte_pulse: got w_r=%b want 0", wb_if.w_r); end
  endtask

  task automatic test_half_and_word();
    drive_load(5'd10, 2'b01, 1'b0, 32'h0000_2002);
    step();
    idle_inputs();
    wb_if.mem_rvalid = 1'b1; wb_if.mem_rdata = 32'h8001_7FFF;
    step();
    idle_inputs();
    n_cmp++; if ({wb_if.w_r, wb_if.w_addr, wb_if.w_data} !== {1'b1, 5'd10, 32'h0000_8001}) begin n_bad++; $display("FAIL uhalf_write: got r=%b a=%0d d=%h want r=1 a=10 d=00008001", wb_if.w_r, wb_if.w_addr, wb_if.w_data); end
    drive_load(5'd11, 2'b01, 1'b1, 32'h0000_2000);
    step();
    idle_inputs();
    wb_if.mem_rvalid = 1'b1; wb_if.mem_rdata = 32'h1234_9ABC;
    step();
    idle_inputs();
    n_cmp++; if ({wb_if.w_r, wb_if.w_addr, wb_if.w_data} !== {1'b1, 5'd11, 32'hFFFF_9ABC}) begin n_bad++; $display("FAIL shalf_write: got r=%b a=%0d d=%h want r=1 a=11 d=ffff9abc", wb_if.w_r, wb_if.w_addr, wb_if.w_data); end
    drive_load(5'd12, 2'b11, 1'b1, 32'h0000_3000);
    step();
    idle_inputs();
    wb_if.mem_rvalid = 1'b1; wb_if.mem_rdata = 32'hCAFE_F00D;
    step();
    idle_inputs();
    n_cmp++; if ({wb_if.w_r, wb_if.w_addr, wb_if.w_data} !== {1'b1, 5'd12, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL word_write: got r=%b a=%0d d=%h want r=1 a=12 d=cafef00d", wb_if.w_r, wb_if.w_addr, wb_if.w_data); end
    drive_load(5'd0, 2'b10, 1'b0, 32'h0000_3004);
    step();
    idle_inputs();
    n_cmp++; if (wb_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL rd0_load_wait: got in_ready=%b want 0", wb_if.in_ready); end
    wb_if.mem_rvalid = 1'b1; wb_if.mem_rdata = 32'h0BAD_0BAD;
    step();
    idle_inputs();
    n_cmp++; if ({wb_if.w_r, wb_if.in_ready, wb_if.w_data} !== {2'b01, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL rd0_load_nowrite: got r=%b rdy=%b d=%h want r=0 rdy=1 d=cafef00d", wb_if.w_r, wb_if.in_ready, wb_if.w_data); end
  endtask

  task automatic test_misaligned();
    drive_load(5'd13, 2'b10, 1'b0, 32'h0000_4001);
    step();
    idle_inputs();
    n_cmp++; if ({wb_if.err_misaligned, wb_if.w_r, wb_if.in_ready} !== 3'b101) begin n_bad++; $display("FAIL mis_word: got em=%b r=%b rdy=%b want 1 0 1", wb_if.err_misaligned, wb_if.w_r, wb_if.in_ready); end
    step();
    n_cmp++; if (wb_if.err_misaligned !== 1'b0) begin n_bad++; $display("FAIL mis_pulse: got em=%b want 0", wb_if.err_misaligned); end
    drive_load(5'd13, 2'b01, 1'b1, 32'h0000_4003);
    step();
    idle_inputs();
    n_cmp++; if ({wb_if.err_misaligned, wb_if.w_r, wb_if.in_ready} !== 3'b101) begin n_bad++; $display("FAIL mis_half: got em=%b r=%b rdy=%b want 1 0 1", wb_if.err_misaligned, wb_if.w_r, wb_if.in_ready); end
    step();
  endtask

  task automatic test_timeout();
    drive_load(5'd14, 2'b10, 1'b0, 32'h0000_5000);
    step();
    idle_inputs();
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++; if ({wb_if.err_timeout, wb_if.in_ready} !== 2'b00) begin n_bad++; $display("FAIL to_wait_%0d: got et=%b rdy=%b want 0 0", k, wb_if.err_timeout, wb_if.in_ready); end
    end
    step();
    n_cmp++; if ({wb_if.err_timeout, wb_if.in_ready, wb_if.w_r} !== 3'b110) begin n_bad++; $display("FAIL to_fire: got et=%b rdy=%b r=%b want 1 1 0", wb_if.err_timeout, wb_if.in_ready, wb_if.w_r); end
    step();
    n_cmp++; if (wb_if.err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_pulse: got et=%b want 0", wb_if.err_timeout); end
    drive_load(5'd15, 2'b10, 1'b0, 32'h0000_5004);
    step();
    idle_inputs();
    step(); step(); step();
    wb_if.mem_rvalid = 1'b1; wb_if.mem_rdata = 32'h1122_3344;
    step();
    idle_inputs();
    n_cmp++; if ({wb_if.w_r, wb_if.err_timeout, wb_if.w_addr, wb_if.w_data} !== {2'b10, 5'd15, 32'h1122_3344}) begin n_bad++; $display("FAIL to_data_wins: got r=%b et=%b a=%0d d=%h want 1 0 15 11223344", wb_if.w_r, wb_if.err_timeout, wb_if.w_addr, wb_if.w_data); end
  endtask

  task automatic test_reset_mid_load();
    drive_load(5'd16, 2'b10, 1'b0, 32'h0000_6000);
    step();
    idle_inputs();
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if ({wb_if.in_ready, wb_if.w_r, wb_if.w_addr, wb_if.w_data, wb_if.err_timeout, wb_if.err_misaligned} !== {2'b10, 5'd0, 32'd0, 2'b00}) begin n_bad++; $display("FAIL rst_mid_outputs: got rdy=%b r=%b a=%0d d=%h et=%b em=%b want 1 0 0 0 0 0", wb_if.in_ready, wb_if.w_r, wb_if.w_addr, wb_if.w_data, wb_if.err_timeout, wb_if.err_misaligned); end
    step();
    rst = 1'b0;
    wb_if.mem_rvalid = 1'b1; wb_if.mem_rdata = 32'h7777_7777;
    step();
    idle_inputs();
    n_cmp++; if (wb_if.w_r !== 1'b0) begin n_bad++; $display("FAIL rst_mid_nowrite: got w_r=%b want 0", wb_if.w_r); end
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++; if ({wb_if.err_timeout, wb_if.w_r} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_quiet_%0d: got et=%b r=%b want 0 0", k, wb_if.err_timeout, wb_if.w_r); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_no_write();
    test_signed_byte();
    test_half_and_word();
    test_misaligned();
    test_timeout();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
